// File: rtl/mat_mult_engine_pkg.sv
// Shared types and default sizing for the matrix multiply engine.
package mat_pkg;

  localparam int N_DEF        = 6;
  localparam int W_DEF        = 27;
  localparam int ACC_W_DEF    = 27;
  localparam int MULT_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ELEM   = 2'd0,
    MATMUL = 2'd1,
    MATMAC = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mat_mult_engine_mult_array.sv
// N*N signed multipliers, MULT_LAT enable-gated register stages each,
// with a single valid flag travelling alongside the products.
module mult_array_p #(
  parameter int N        = 6,
  parameter int W        = 27,
  parameter int MULT_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_i,
  input  logic [N*N*W-1:0]     a_i,
  input  logic [N*N*W-1:0]     b_i,
  output logic [N*N*2*W-1:0]   prod_o,
  output logic                 valid_o
);

  logic [MULT_LAT-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= valid_i;
      for (int s = 1; s < MULT_LAT; s++) valid_q[s] <= valid_q[s-1];
    end
  end

  assign valid_o = valid_q[MULT_LAT-1];

  for (genvar gi = 0; gi < N*N; gi++) begin : g_mul
    logic signed [W-1:0]   a_op;
    logic signed [W-1:0]   b_op;
    logic signed [2*W-1:0] pipe_q [MULT_LAT];

    assign a_op = a_i[gi*W +: W];
    assign b_op = b_i[gi*W +: W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < MULT_LAT; s++) pipe_q[s] <= '0;
      end else if (en) begin
        // Operands are widened first so the full signed product is kept.
        pipe_q[0] <= (2*W)'(a_op) * (2*W)'(b_op);
        for (int s = 1; s < MULT_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign prod_o[gi*2*W +: 2*W] = pipe_q[MULT_LAT-1];
  end

endmodule

// File: rtl/mat_mult_engine.sv
// Matrix engine: element-wise, C=A*B and C+=A*B over captured operands,
// one k-step per enabled cycle into a pipelined multiplier array.
module mat_mult_engine
  import mat_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [N*N*W-1:0]       dataa,
  input  logic [N*N*W-1:0]       datab,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [N*N*ACC_W-1:0]   result
);

  localparam int KW = $clog2(N);
  localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d, last_k;
  logic [DW-1:0]       drain_q, drain_d;
  mode_e               mode_q;
  logic                replace_q;
  logic signed [W-1:0] a_q [N][N];
  logic signed [W-1:0] b_q [N][N];

  logic                accept;
  logic [N*N*W-1:0]    op_a, op_b;
  logic [N*N*2*W-1:0]  prod;
  logic                prod_valid;
  logic                prod_unused;

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy   = (state_q == S_RUN)  || (state_q == S_DRAIN);
  assign done   = (state_q == S_DONE);
  assign accept = en && ready && start && (mode_e'(mode) != RSVD);
  assign last_k = (mode_q == ELEM) ? '0 : KW'(N-1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: if (accept) begin state_d = S_RUN; k_d = '0; end
      S_RUN: begin
        if (k_q == last_k) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(MULT_LAT-1)) state_d = S_DONE;
        else                            drain_d = drain_q + 1'b1;
      end
      S_DONE: begin
        if (accept) begin state_d = S_RUN; k_d = '0; end
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      mode_q    <= ELEM;
      replace_q <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
    end else if (en) begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      if (accept) begin
        mode_q    <= mode_e'(mode);
        // MATMAC folds its first product onto the held result.
        replace_q <= (mode_e'(mode) != MATMAC);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            a_q[i][j] <= dataa[(i*N+j)*W +: W];
            b_q[i][j] <= datab[(i*N+j)*W +: W];
          end
      end else if (prod_valid) begin
        replace_q <= 1'b0;
      end
    end
  end

  mult_array_p #(.N(N), .W(W), .MULT_LAT(MULT_LAT)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .valid_i (state_q == S_RUN),
    .a_i     (op_a),
    .b_i     (op_b),
    .prod_o  (prod),
    .valid_o (prod_valid)
  );

  // Upper product bits are dropped when ACC_W < 2*W.
  assign prod_unused = ^prod;

  for (genvar gi = 0; gi < N*N; gi++) begin : g_cell
    localparam int ROW = gi / N;
    localparam int COL = gi % N;
    logic [ACC_W-1:0] prod_trunc;
    logic [ACC_W-1:0] acc_q;

    assign op_a[gi*W +: W] = (mode_q == ELEM) ? a_q[ROW][COL] : a_q[ROW][k_q];
    assign op_b[gi*W +: W] = (mode_q == ELEM) ? b_q[ROW][COL] : b_q[k_q][COL];
    assign prod_trunc      = prod[gi*2*W +: ACC_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                    acc_q <= '0;
      else if (en && prod_valid)  acc_q <= (replace_q ? '0 : acc_q) + prod_trunc;
    end

    assign result[gi*ACC_W +: ACC_W] = acc_q;
  end

endmodule

// File: tb/tb_mat_mult_engine.sv
// Scoreboard bench: two engines (ACC_W 27 and 8) share stimulus; a reference
// model computes expected matrices and done cycles, monitors compare on done.
module tb_mat_mult_engine;
  import mat_pkg::*;

  localparam int N = 2;
  localparam int W = 27;
  localparam int L = 1;

  logic             clk = 1'b0;
  logic             rst, en, start;
  logic [1:0]       mode;
  logic [N*N*W-1:0] dataa, datab;
  logic             ready, busy, done, ready8, busy8, done8;
  logic [N*N*27-1:0] result;
  logic [N*N*8-1:0]  result8;

  always #5 clk = ~clk;

  mat_mult_engine #(.N(N), .W(W), .ACC_W(27), .MULT_LAT(L)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .dataa(dataa), .datab(datab), .ready(ready), .busy(busy),
    .done(done), .result(result));

  mat_mult_engine #(.N(N), .W(W), .ACC_W(8), .MULT_LAT(L)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .dataa(dataa), .datab(datab), .ready(ready8), .busy(busy8),
    .done(done8), .result(result8));

  typedef struct {
    logic [107:0] res;
    int           done_cyc;
    int           stall_base;
  } item_t;

  item_t  q27[$];
  item_t  q8[$];
  int     checks = 0;
  int     errs = 0;
  int     cyc = 0;
  int     stall_total = 0;
  int     opa[2][2];
  int     opb[2][2];
  longint m27[2][2];
  longint m8[2][2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic cmp_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: one pop per done pulse (a pulse frozen by en=0 counts once).
  bit    hold27 = 1'b0;
  bit    hold8  = 1'b0;
  item_t it27, it8;
  always @(negedge clk) begin
    if (done && !hold27) begin
      if (q27.size() == 0) begin
        checks++; errs++;
        $display("FAIL done27_unexpected: got done=1 at cycle %0d required no done", cyc);
      end else begin
        it27 = q27.pop_front();
        cmp("result27", result, it27.res);
        cmp_int("latency27", cyc, it27.done_cyc + (stall_total - it27.stall_base));
      end
    end
    hold27 = done && !en;
    if (done8 && !hold8) begin
      if (q8.size() == 0) begin
        checks++; errs++;
        $display("FAIL done8_unexpected: got done=1 at cycle %0d required no done", cyc);
      end else begin
        it8 = q8.pop_front();
        cmp("result8", {76'd0, result8}, it8.res);
        cmp_int("latency8", cyc, it8.done_cyc + (stall_total - it8.stall_base));
      end
    end
    hold8 = done8 && !en;
  end

  function automatic longint wrapv(input longint v, input int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    return v & mask;
  endfunction

  function automatic int rnd_op();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 20)) - 10;
    return int'($urandom_range(0, (1 << 27) - 1)) - (1 << 26);
  endfunction

  // Reference: plain matrix arithmetic, wrapped to each accumulator width.
  task automatic push_model(input logic [1:0] md, input int drive_cyc);
    item_t  e27, e8;
    longint s;
    int     k;
    e27.res = '0;
    e8.res  = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        if (md == 2'd0) s = longint'(opa[i][j]) * longint'(opb[i][j]);
        else for (int kk = 0; kk < 2; kk++) s += longint'(opa[i][kk]) * longint'(opb[kk][j]);
        m27[i][j] = wrapv(((md == 2'd2) ? m27[i][j] : 0) + s, 27);
        m8[i][j]  = wrapv(((md == 2'd2) ? m8[i][j]  : 0) + s, 8);
        e27.res[(i*2+j)*27 +: 27] = m27[i][j][26:0];
        e8.res[(i*2+j)*8 +: 8]    = m8[i][j][7:0];
      end
    k = (md == 2'd0) ? 1 : 2;
    e27.done_cyc   = drive_cyc + k + L + 1;
    e27.stall_base = stall_total;
    e8.done_cyc    = e27.done_cyc;
    e8.stall_base  = stall_total;
    q27.push_back(e27);
    q8.push_back(e8);
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        dataa[(i*2+j)*27 +: 27] = opa[i][j][26:0];
        datab[(i*2+j)*27 +: 27] = opb[i][j][26:0];
      end
  endtask

  task automatic set_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
    opa[0][0] = a00; opa[0][1] = a01; opa[1][0] = a10; opa[1][1] = a11;
    opb[0][0] = b00; opb[0][1] = b01; opb[1][0] = b10; opb[1][1] = b11;
  endtask

  // Called #1 after a rising edge with ready high; returns the same way.
  task automatic do_op(input logic [1:0] md, input int stall_at, input int stall_len,
                       input bit rst_in_drain);
    int n, k, drive_cyc;
    drive_ops();
    mode  = md;
    start = 1'b1;
    en    = 1'b1;
    drive_cyc = cyc;
    k = (md == 2'd0) ? 1 : 2;
    if (md != 2'd3 && !rst_in_drain) push_model(md, drive_cyc);
    @(posedge clk); #1;
    start = 1'b0;
    if (md == 2'd3) begin
      for (int c = 0; c < 3; c++) begin
        cmp_bit("rsvd_ready", ready, 1'b1);
        cmp_bit("rsvd_busy", busy, 1'b0);
        @(posedge clk); #1;
      end
      return;
    end
    cmp_bit("accept_busy", busy, 1'b1);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      if (rst_in_drain && n == k) begin
        cmp_bit("drain_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        cmp("rst_result27", result, '0);
        cmp("rst_result8", {76'd0, result8}, '0);
        cmp_bit("rst_done", done, 1'b0);
        cmp_bit("rst_ready", ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            m27[i][j] = 0;
            m8[i][j]  = 0;
          end
        en = 1'b1; start = 1'b0;
        return;
      end
      // Busy cycles: stalls plus garbage inputs that must be ignored.
      en = !(n >= stall_at && n < stall_at + stall_len);
      if (!en) stall_total++;
      start = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      for (int e = 0; e < 4; e++) begin
        dataa[e*27 +: 27] = 27'($urandom);
        datab[e*27 +: 27] = 27'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    en = 1'b1;
    start = 1'b0;
    if (n >= 100) begin
      checks++; errs++;
      $display("FAIL timeout: got no ready after %0d cycles required ready", n);
    end
  endtask

  initial begin
    int md, kk, sat, slen;
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 2'd0; dataa = '0; datab = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        m27[i][j] = 0;
        m8[i][j]  = 0;
      end
    repeat (3) @(posedge clk);
    #1;
    cmp_bit("reset_ready", ready, 1'b1);
    cmp_bit("reset_busy", busy, 1'b0);
    cmp_bit("reset_done", done, 1'b0);
    cmp("reset_result27", result, '0);
    cmp("reset_result8", {76'd0, result8}, '0);
    rst = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    do_op(2'd1, 0, 0, 1'b0);                    // [[19,22],[43,50]]
    do_op(2'd2, 0, 0, 1'b0);                    // [[38,44],[86,100]]
    do_op(2'd0, 0, 0, 1'b0);                    // [[5,12],[21,32]]
    set_ab(-3, 0, 0, 100, 5, 0, 0, 3);
    do_op(2'd1, 0, 0, 1'b0);                    // 300 wraps to 44 at 8 bits
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    do_op(2'd1, 1, 3, 1'b0);                    // three stall cycles mid-run
    do_op(2'd3, 0, 0, 1'b0);                    // reserved mode ignored
    do_op(2'd1, 0, 0, 1'b1);                    // abandoned by reset in drain
    do_op(2'd1, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      md = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          opa[i][j] = rnd_op();
          opb[i][j] = rnd_op();
        end
      kk = (md == 0) ? 1 : 2;
      sat = 0; slen = 0;
      if ($urandom_range(0, 2) == 0) begin
        sat  = int'($urandom_range(0, kk));
        slen = int'($urandom_range(1, 3));
      end
      do_op(2'(md), sat, slen, 1'b0);
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    repeat (6) begin @(posedge clk); #1; end
    cmp_int("q27_drained", q27.size(), 0);
    cmp_int("q8_drained", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
